// File: rtl/sd_pkg.sv
// Shared types and helpers for the radix-4 signed-digit to two's complement converter.
package sd_pkg;

  localparam int SD_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CONV = 2'b01,
    DONE = 2'b10
  } state_e;

  // Digit codes are 2-bit two's complement, so the value is just the sign-extended code.
  function automatic logic signed [2:0] sd_val(input logic [SD_W-1:0] d);
    return $signed({d[1], d});
  endfunction

endpackage

// File: rtl/sd_digit_step.sv
// One radix-4 conversion step: adds the incoming borrow to an SD digit and splits the
// sum into a 2-bit result digit and an outgoing borrow.
module sd_digit_step
  import sd_pkg::*;
(
  input  logic [SD_W-1:0] d,
  input  logic            borrow_in,
  output logic [SD_W-1:0] r,
  output logic            borrow_out
);

  logic signed [2:0] w_s;

  // s lies in -3..+1, so its low bits are s mod 4 and its sign bit is floor(s/4) == -1.
  always_comb begin
    w_s        = sd_val(d) + (borrow_in ? 3'sb111 : 3'sb000);
    r          = w_s[1:0];
    borrow_out = w_s[2];
  end

endmodule

// File: rtl/sd_to_binary_converter.sv
// Digit-serial radix-4 signed-digit to two's complement converter, one digit per cycle,
// LSB first, with valid/ready handshakes on input and output.
module sd_to_binary_converter
  import sd_pkg::*;
#(
  parameter int NDIG  = 4,
  parameter int OUT_W = 2*NDIG+3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*NDIG-1:0]    sd_vec,
  input  logic [SD_W-1:0]      sd_top,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     bin_out,
  output logic                 busy
);

  localparam int SR_W  = SD_W*(NDIG+1);
  localparam int CNT_W = $clog2(NDIG+1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG);

  state_e            r_state;
  logic [SR_W-1:0]   r_shift;
  logic [SR_W-1:0]   r_res;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_borrow;
  logic              r_sign;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_busy;

  logic [SD_W-1:0]   w_r;
  logic              w_borrow;

  sd_digit_step u_step (
    .d          (r_shift[SD_W-1:0]),
    .borrow_in  (r_borrow),
    .r          (w_r),
    .borrow_out (w_borrow)
  );

  // Result digits enter at the top of r_res and shift down, so after NDIG+1 steps
  // digit 0 sits in the lowest bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_res       <= '0;
      r_cnt       <= '0;
      r_borrow    <= 1'b0;
      r_sign      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_shift    <= {sd_top, sd_vec};
            r_res      <= '0;
            r_cnt      <= '0;
            r_borrow   <= 1'b0;
            r_sign     <= 1'b0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= CONV;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        CONV: begin
          r_shift  <= {{SD_W{1'b0}}, r_shift[SR_W-1:SD_W]};
          r_res    <= {w_r, r_res[SR_W-1:SD_W]};
          r_borrow <= w_borrow;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_CNT) begin
            r_sign      <= w_borrow;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_state <= CONV;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end else begin
            r_state <= DONE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign bin_out   = {r_sign, r_res};

endmodule
